mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 35 +++
 rtl/mem_port_arbiter_fairness.sv | 65 ++++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared CPU memory definitions: arbiter FSM state encoding, port-owner codes,
// the registered memory-command bundle and a helper that sizes the
// data-streak counter.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_cmd_t;

  // Bits needed to count 0..limit (at least one bit so a limit of 0 still
  // yields a legal vector).
  function automatic int streak_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_fairness.sv
// ---------------------------------------------------------------------------
// mem_arb_fairness
// Picks the winner between the instruction-fetch and data ports and tracks
// how many data grants in a row were given while a fetch was waiting.
//
// Ports
//   clk, srst : clock and synchronous active-high reset
//   arb_en    : an arbitration happens on this edge (IDLE with a request)
//   i_req     : fetch request pending
//   d_req     : data request pending (read or write)
//   winner    : combinational grant decision for the current cycle
// ---------------------------------------------------------------------------
module mem_arb_fairness
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   srst,
  input  logic   arb_en,
  input  logic   i_req,
  input  logic   d_req,
  output owner_t winner
);

  localparam int              SW      = streak_width(STARVE_LIMIT);
  localparam logic [SW-1:0]   LIMIT_V = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak_reg;
  logic [SW-1:0] streak_next;
  logic          starve_hit;

  // A limit of zero means data always wins; the counter then never leaves 0.
  assign starve_hit = (STARVE_LIMIT > 0) && (streak_reg == LIMIT_V);

  always_comb begin
    winner = OWNER_I;
    if (d_req && !(i_req && starve_hit)) begin
      winner = OWNER_D;
    end
  end

  always_comb begin
    streak_next = streak_reg;
    if (arb_en) begin
      if ((winner == OWNER_D) && i_req) begin
        if (streak_reg != LIMIT_V) begin
          streak_next = streak_reg + SW'(1);
        end
      end else begin
        // Fetch granted, or nobody was waiting on the fetch side.
        streak_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified memory port between an instruction-fetch port and a
// data port. One transaction at a time: IDLE arbitrates and registers the
// command, ACCESS holds it until the memory stops stalling, RELEASE gives the
// owning requester one cycle with its busywait low.
//
// Ports
//   CLK, RESET                 : clock, synchronous active-high reset
//   I_READ, I_ADDRESS          : fetch request and byte address
//   I_READDATA, I_BUSYWAIT     : registered fetch word, fetch stall
//   D_READ, D_WRITE            : data requests (both high = write)
//   D_ADDRESS, D_WRITEDATA     : data address and store data
//   D_READDATA, D_BUSYWAIT     : registered load word, data stall
//   M_READ, M_WRITE            : registered memory command
//   M_ADDRESS, M_WRITEDATA     : registered memory address / store data
//   M_READDATA, M_BUSYWAIT     : memory response, busy while serving
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [WORD_W-1:0] I_ADDRESS,
  output logic [WORD_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [WORD_W-1:0] D_ADDRESS,
  input  logic [WORD_W-1:0] D_WRITEDATA,
  output logic [WORD_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [WORD_W-1:0] M_ADDRESS,
  output logic [WORD_W-1:0] M_WRITEDATA,
  input  logic [WORD_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT
);

  arb_state_t state_reg, state_next;
  owner_t     owner_reg, owner_next;
  mem_cmd_t   cmd_reg, cmd_next;
  owner_t     arb_winner;

  logic d_req;
  logic any_req;
  logic arb_en;
  logic capture_en;

  assign d_req      = D_READ | D_WRITE;
  assign any_req    = I_READ | d_req;
  assign arb_en     = (state_reg == ST_IDLE) && any_req;
  // Only reads return data; a write (including read+write collision) leaves
  // both read-data registers alone.
  assign capture_en = (state_reg == ST_ACCESS) && !M_BUSYWAIT && cmd_reg.rd;

  mem_arb_fairness #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_fairness (
    .clk   (CLK),
    .srst  (RESET),
    .arb_en(arb_en),
    .i_req (I_READ),
    .d_req (d_req),
    .winner(arb_winner)
  );

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    cmd_next   = cmd_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          owner_next = arb_winner;
          state_next = ST_ACCESS;
          if (arb_winner == OWNER_D) begin
            cmd_next.addr  = D_ADDRESS;
            cmd_next.wdata = D_WRITEDATA;
            cmd_next.wr    = D_WRITE;
            cmd_next.rd    = D_READ & ~D_WRITE;
          end else begin
            cmd_next.addr = I_ADDRESS;
            cmd_next.rd   = 1'b1;
            cmd_next.wr   = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        // Requests are ignored here: a dropped or re-addressed request does
        // not disturb the transaction already on the memory port.
        if (!M_BUSYWAIT) begin
          cmd_next.rd = 1'b0;
          cmd_next.wr = 1'b0;
          state_next  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWNER_I;
      cmd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cmd_reg   <= cmd_next;
    end
  end

  // Per-requester read-data register and busywait; index 0 = fetch, 1 = data.
  logic [1:0]              req_vec;
  logic [1:0]              busy_vec;
  logic [1:0][WORD_W-1:0]  rdata_bus;

  assign req_vec = {d_req, I_READ};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam owner_t OWN = (gi == 0) ? OWNER_I : OWNER_D;

      logic              owns;
      logic [WORD_W-1:0] rdata_reg;

      assign owns = (owner_reg == OWN);

      // Combinational so the requester sees the release in the same cycle;
      // it also keeps following the request while RESET is high.
      assign busy_vec[gi] = req_vec[gi] & ~((state_reg == ST_RELEASE) && owns);

      always_ff @(posedge CLK) begin
        if (RESET) begin
          rdata_reg <= '0;
        end else if (capture_en && owns) begin
          rdata_reg <= M_READDATA;
        end
      end

      assign rdata_bus[gi] = rdata_reg;
    end
  endgenerate

  assign I_READDATA  = rdata_bus[0];
  assign D_READDATA  = rdata_bus[1];
  assign I_BUSYWAIT  = busy_vec[0];
  assign D_BUSYWAIT  = busy_vec[1];

  assign M_READ      = cmd_reg.rd;
  assign M_WRITE     = cmd_reg.wr;
  assign M_ADDRESS   = cmd_reg.addr;
  assign M_WRITEDATA = cmd_reg.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives the fetch and data ports of mem_port_arbiter against a small memory
// model with programmable stall length. Every expected memory command is
// queued when the request is driven and compared when the command appears on
// the memory port; read data, busywait and reset values are checked inline.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_READ;
  logic [31:0] I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        D_READ;
  logic        D_WRITE;
  logic [31:0] D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        M_READ;
  logic        M_WRITE;
  logic [31:0] M_ADDRESS;
  logic [31:0] M_WRITEDATA;
  logic [31:0] M_READDATA;
  logic        M_BUSYWAIT;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mem_lat  = 0;
  int   busy_cnt = 0;
  int   n_grant  = 0;
  logic cmd_prev = 1'b0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .I_READ     (I_READ),
    .I_ADDRESS  (I_ADDRESS),
    .I_READDATA (I_READDATA),
    .I_BUSYWAIT (I_BUSYWAIT),
    .D_READ     (D_READ),
    .D_WRITE    (D_WRITE),
    .D_ADDRESS  (D_ADDRESS),
    .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA (D_READDATA),
    .D_BUSYWAIT (D_BUSYWAIT),
    .M_READ     (M_READ),
    .M_WRITE    (M_WRITE),
    .M_ADDRESS  (M_ADDRESS),
    .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA (M_READDATA),
    .M_BUSYWAIT (M_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0030_8093;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Memory: busy for mem_lat cycles after a command appears, then ready.
  assign M_READDATA = mem_word(M_ADDRESS);
  assign M_BUSYWAIT = (M_READ | M_WRITE) && (busy_cnt < mem_lat);

  always @(posedge CLK) begin
    if (!(M_READ | M_WRITE)) busy_cnt <= 0;
    else if (M_BUSYWAIT)     busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic push(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  // Scoreboard: each new command on the memory port pops one expectation.
  initial begin
    txn_t e;
    logic cmd_now;
    forever begin
      @(negedge CLK);
      cmd_now = M_READ | M_WRITE;
      if (cmd_now && !cmd_prev) begin
        n_grant++;
        $display("grant %0d: rd=%0b wr=%0b addr=0x%08h wdata=0x%08h",
                 n_grant, M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_grant", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_rd", 32'(M_READ), 32'(e.rd));
          check("sb_wr", 32'(M_WRITE), 32'(e.wr));
          check("sb_addr", M_ADDRESS, e.addr);
          if (e.wr) check("sb_wdata", M_WRITEDATA, e.wdata);
        end
      end
      cmd_prev = cmd_now;
    end
  end

  task automatic wait_grant(input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge CLK);
      if ((M_READ | M_WRITE) && (M_ADDRESS == a)) ok = 1'b1;
    end
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
  endtask

  // Returns how many sampled cycles the selected busywait stayed high.
  task automatic wait_low(input bit is_i, output int highs);
    bit ok;
    ok    = 1'b0;
    highs = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge CLK);
      if ((is_i ? I_BUSYWAIT : D_BUSYWAIT) == 1'b0) ok = 1'b1;
      else highs++;
    end
    if (!ok) check("busy_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h;
    int dn;
    int in_cnt;
    bit i_act;
    bit d_act;
    bit d_first;

    RESET = 1'b1;
    I_READ = 1'b0; I_ADDRESS = '0;
    D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_m_read", 32'(M_READ), 32'd0);
    check("rst_m_write", 32'(M_WRITE), 32'd0);
    check("rst_m_addr", M_ADDRESS, 32'd0);
    check("rst_m_wdata", M_WRITEDATA, 32'd0);
    check("rst_i_rdata", I_READDATA, 32'd0);
    check("rst_d_rdata", D_READDATA, 32'd0);
    check("rst_d_busy", 32'(D_BUSYWAIT), 32'd0);
    I_READ = 1'b1;
    @(negedge CLK);
    check("rst_i_busy_follows", 32'(I_BUSYWAIT), 32'd1);
    check("rst_no_grant", 32'(M_READ), 32'd0);
    I_READ = 1'b0;
    RESET  = 1'b0;
    @(negedge CLK);

    // Fetch only, memory busy for two cycles
    mem_lat = 2;
    push(1'b1, 1'b0, 32'h4, 32'h0);
    I_ADDRESS = 32'h4; I_READ = 1'b1;
    wait_low(1'b1, h);
    check("t1_busy_cycles", 32'(h), 32'd3);
    check("t1_i_rdata", I_READDATA, 32'h0030_8093);
    check("t1_m_read_dropped", 32'(M_READ), 32'd0);
    @(negedge CLK);
    check("t1_busy_one_cycle", 32'(I_BUSYWAIT), 32'd1);
    I_READ = 1'b0;
    @(negedge CLK);

    // Simultaneous fetch and store: store goes first
    mem_lat = 1;
    push(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    push(1'b1, 1'b0, 32'h8, 32'h0);
    I_ADDRESS = 32'h8; I_READ = 1'b1;
    D_ADDRESS = 32'h100; D_WRITEDATA = 32'hDEAD_BEEF; D_WRITE = 1'b1;
    i_act = 1'b1; d_act = 1'b1; d_first = 1'b0;
    for (int k = 0; k < 60 && (i_act || d_act); k++) begin
      @(negedge CLK);
      if (d_act && !D_BUSYWAIT) begin
        d_act = 1'b0; D_WRITE = 1'b0; d_first = i_act;
      end
      if (i_act && !I_BUSYWAIT) begin
        check("t2_i_rdata", I_READDATA, mem_word(32'h8));
        i_act = 1'b0; I_READ = 1'b0;
      end
    end
    check("t2_done", {30'd0, i_act, d_act}, 32'd0);
    check("t2_store_first", 32'(d_first), 32'd1);
    check("t2_d_rdata_untouched", D_READDATA, 32'd0);
    @(negedge CLK);

    // Starvation: data re-requests continuously while a fetch waits
    mem_lat = 0;
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'h0);
    push(1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 4; k < 8; k++) push(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'h0);
    push(1'b1, 1'b0, 32'h24, 32'h0);
    dn = 0; in_cnt = 0;
    I_ADDRESS = 32'h20; I_READ = 1'b1;
    D_ADDRESS = 32'h200; D_READ = 1'b1;
    for (int k = 0; k < 200 && (in_cnt < 2 || dn < 8); k++) begin
      @(negedge CLK);
      if (D_READ && !D_BUSYWAIT) begin
        check("t3_d_rdata", D_READDATA, mem_word(D_ADDRESS));
        dn++;
        if (dn < 8) D_ADDRESS = 32'h200 + 32'(4 * dn);
        else        D_READ = 1'b0;
      end
      if (I_READ && !I_BUSYWAIT) begin
        check("t3_i_rdata", I_READDATA, mem_word(I_ADDRESS));
        in_cnt++;
        if (in_cnt < 2) I_ADDRESS = 32'h24;
        else            I_READ = 1'b0;
      end
    end
    check("t3_d_count", 32'(dn), 32'd8);
    check("t3_i_count", 32'(in_cnt), 32'd2);
    @(negedge CLK);

    // Flush mid-access, then data address changes during its own access
    mem_lat = 3;
    push(1'b1, 1'b0, 32'h30, 32'h0);
    push(1'b1, 1'b0, 32'h300, 32'h0);
    I_ADDRESS = 32'h30; I_READ = 1'b1;
    wait_grant(32'h30);
    I_READ = 1'b0;
    D_ADDRESS = 32'h300; D_READ = 1'b1;
    @(negedge CLK);
    check("t4_hold_m_read", 32'(M_READ), 32'd1);
    check("t4_hold_m_addr", M_ADDRESS, 32'h30);
    check("t4_d_busy", 32'(D_BUSYWAIT), 32'd1);
    wait_grant(32'h300);
    D_ADDRESS = 32'h304;
    @(negedge CLK);
    check("t4_addr_stable", M_ADDRESS, 32'h300);
    wait_low(1'b0, h);
    check("t4_d_rdata", D_READDATA, mem_word(32'h300));
    check("t4_flushed_i_rdata", I_READDATA, mem_word(32'h30));
    D_READ = 1'b0;
    @(negedge CLK);

    // Reset while a fetch is in ACCESS
    mem_lat = 5;
    push(1'b1, 1'b0, 32'h40, 32'h0);
    I_ADDRESS = 32'h40; I_READ = 1'b1;
    wait_grant(32'h40);
    RESET = 1'b1;
    push(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge CLK);
    check("t5_m_read", 32'(M_READ), 32'd0);
    check("t5_m_write", 32'(M_WRITE), 32'd0);
    check("t5_m_addr", M_ADDRESS, 32'd0);
    check("t5_m_wdata", M_WRITEDATA, 32'd0);
    check("t5_i_rdata", I_READDATA, 32'd0);
    check("t5_d_rdata", D_READDATA, 32'd0);
    check("t5_i_busy", 32'(I_BUSYWAIT), 32'd1);
    RESET = 1'b0;
    mem_lat = 0;
    wait_low(1'b1, h);
    check("t5_regrant_rdata", I_READDATA, mem_word(32'h40));
    I_READ = 1'b0;
    @(negedge CLK);

    // Read+write collision is a write and leaves D_READDATA alone
    mem_lat = 1;
    push(1'b1, 1'b0, 32'h500, 32'h0);
    D_ADDRESS = 32'h500; D_READ = 1'b1;
    wait_low(1'b0, h);
    check("t6_pre_d_rdata", D_READDATA, mem_word(32'h500));
    D_READ = 1'b0;
    @(negedge CLK);
    push(1'b0, 1'b1, 32'h400, 32'h1234_5678);
    D_ADDRESS = 32'h400; D_WRITEDATA = 32'h1234_5678;
    D_READ = 1'b1; D_WRITE = 1'b1;
    wait_low(1'b0, h);
    check("t6_m_write_dropped", 32'(M_WRITE), 32'd0);
    check("t6_d_rdata_kept", D_READDATA, mem_word(32'h500));
    D_READ = 1'b0; D_WRITE = 1'b0;

    repeat (3) @(negedge CLK);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
